// File: rtl/systolic_pkg.sv
// Shared constants, data word type and tap-count helper for the systolic
// convolution engine.
package systolic_pkg;

    localparam int WIDTH = 16;
    localparam int ROW   = 32;
    localparam int COL   = 32;
    localparam int CNT_W = 6;

    localparam logic [CNT_W-1:0] CNT_MAX = 6'd63;

    typedef logic [WIDTH-1:0] word_t;

    // A weight_dim of zero encodes the full 32-tap column.
    function automatic logic [CNT_W-1:0] taps_of(input logic [4:0] dim);
        logic [CNT_W-1:0] taps_v;
        if (dim == 5'd0) begin
            taps_v = 6'd32;
        end else begin
            taps_v = {1'b0, dim};
        end
        return taps_v;
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// One weight-stationary multiply-accumulate cell: shiftable weight, feature
// pass-through register and wrapping psum register.
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int width = WIDTH
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             weight_en,
    input  logic [width-1:0] weight_in,
    input  logic [width-1:0] f_in,
    input  logic [width-1:0] psum_in,
    output logic [width-1:0] weight_out,
    output logic [width-1:0] f_out,
    output logic [width-1:0] psum_out
);

    logic [width-1:0] weight_r;
    logic [width-1:0] f_r;
    logic [width-1:0] psum_r;
    logic [width-1:0] prod_s;
    logic [width-1:0] mac_s;

    // Product and sum both wrap to the data width.
    always_comb begin
        prod_s = weight_r * f_in;
        mac_s  = psum_in + prod_s;
    end

    // Weight shift register stage, held while weight_en is low.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            weight_r <= {width{1'b0}};
        end else if (weight_en) begin
            weight_r <= weight_in;
        end
    end

    // Feature and partial-sum registers advance on every edge.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            f_r    <= {width{1'b0}};
            psum_r <= {width{1'b0}};
        end else begin
            f_r    <= f_in;
            psum_r <= mac_s;
        end
    end

    assign weight_out = weight_r;
    assign f_out      = f_r;
    assign psum_out   = psum_r;

endmodule

// File: rtl/systolic_top.sv
// Weight-stationary systolic array: PE grid, per-column result mux selecting
// row weight_dim-1, and the run counter driving conv_finish.
module systolic_top
    import systolic_pkg::*;
#(
    parameter int width = WIDTH,
    parameter int col   = COL,
    parameter int row   = ROW
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             conv_ctrl,
    input  logic [col-1:0]   weight_en,
    input  logic [4:0]       weight_dim,
    input  logic [width-1:0] weight_input2  [col-1:0],
    input  logic [width-1:0] feature_input2 [row-1:0],
    output logic [width-1:0] systolic_out   [col-1:0],
    output logic             conv_finish
);

    logic [width-1:0] w_s    [row][col];
    logic [width-1:0] f_s    [row][col];
    logic [width-1:0] psum_s [row][col];

    logic [4:0]       sel_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic [CNT_W-1:0] thr_s;
    logic             finish_r;

    for (genvar gr = 0; gr < row; gr++) begin : g_row
        for (genvar gc = 0; gc < col; gc++) begin : g_col
            logic [width-1:0] w_in_s;
            logic [width-1:0] f_in_s;
            logic [width-1:0] psum_in_s;

            if (gr == 0) begin : g_top
                assign w_in_s    = weight_input2[gc];
                assign psum_in_s = {width{1'b0}};
            end else begin : g_inner
                assign w_in_s    = w_s[gr-1][gc];
                assign psum_in_s = psum_s[gr-1][gc];
            end

            if (gc == 0) begin : g_left
                assign f_in_s = feature_input2[gr];
            end else begin : g_right
                assign f_in_s = f_s[gr][gc-1];
            end

            systolic_pe #(.width(width)) u_pe (
                .clk       (clk),
                .nrst      (nrst),
                .weight_en (weight_en[gc]),
                .weight_in (w_in_s),
                .f_in      (f_in_s),
                .psum_in   (psum_in_s),
                .weight_out(w_s[gr][gc]),
                .f_out     (f_s[gr][gc]),
                .psum_out  (psum_s[gr][gc])
            );
        end
    end

    // weight_dim==0 wraps to row 31, the full-depth tap.
    assign sel_s = weight_dim - 5'd1;

    for (genvar gc = 0; gc < col; gc++) begin : g_out
        assign systolic_out[gc] = psum_s[sel_s][gc];
    end

    // Saturating run length and the threshold it must reach.
    always_comb begin
        thr_s = taps_of(weight_dim) + 6'd1;
        if (cnt_r == CNT_MAX) begin
            cnt_next_s = cnt_r;
        end else begin
            cnt_next_s = cnt_r + 6'd1;
        end
    end

    // Run counter; conv_finish is registered alongside it.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_r    <= 6'd0;
            finish_r <= 1'b0;
        end else if (!conv_ctrl) begin
            cnt_r    <= 6'd0;
            finish_r <= 1'b0;
        end else begin
            cnt_r    <= cnt_next_s;
            finish_r <= (cnt_next_s >= thr_s);
        end
    end

    assign conv_finish = finish_r;

endmodule

// File: tb/tb_systolic_top.sv
// Self-checking bench: directed vector table plus randomized traffic checked
// against a history-based dot-product model of the array.
module tb_systolic_top;

    localparam int W = 16;
    localparam int C = 32;
    localparam int R = 32;
    localparam int HMAX = 1024;

    logic         clk = 1'b0;
    logic         nrst;
    logic         conv_ctrl;
    logic [C-1:0] weight_en;
    logic [4:0]   weight_dim;
    logic [W-1:0] weight_input2  [C-1:0];
    logic [W-1:0] feature_input2 [R-1:0];
    logic [W-1:0] systolic_out   [C-1:0];
    logic         conv_finish;

    systolic_top dut (
        .clk           (clk),
        .nrst          (nrst),
        .conv_ctrl     (conv_ctrl),
        .weight_en     (weight_en),
        .weight_dim    (weight_dim),
        .weight_input2 (weight_input2),
        .feature_input2(feature_input2),
        .systolic_out  (systolic_out),
        .conv_finish   (conv_finish)
    );

    always #5 clk = ~clk;

    // Reference state: loaded weights, feature history since reset,
    // edge of last weight movement, consecutive running edges.
    logic [W-1:0] wm [R][C];
    logic [W-1:0] xh [HMAX][R];
    int n;
    int last_wchange;
    int ccount;
    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [W-1:0] w;
        logic [W-1:0] f;
        logic [4:0]   dim;
        logic [W-1:0] e0;
        logic [W-1:0] e1;
    } vec_t;
    vec_t vecs [5];

    function automatic int taps(input logic [4:0] d);
        return (d == 5'd0) ? 32 : int'(d);
    endfunction

    // Column c after n edges: dot product over active taps, each tap seeing the
    // feature its row received (r-k) edges earlier and delayed c more columns.
    function automatic logic [W-1:0] exp_out(input int c);
        logic [W-1:0] acc;
        logic [31:0]  p;
        int e, r, idx;
        acc = 16'd0;
        if (n == 0) return acc;
        e = n - 1;
        r = taps(weight_dim) - 1;
        for (int k = 0; k <= r; k++) begin
            idx = e - (r - k) - c;
            if (idx >= 0) begin
                p = wm[k][c] * xh[idx][k];
                acc = acc + p[15:0];
            end
        end
        return acc;
    endfunction

    function automatic bit out_valid();
        return (n - taps(weight_dim) - 1) >= last_wchange;
    endfunction

    task automatic model_reset();
        n = 0;
        last_wchange = -100;
        ccount = 0;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                wm[r][c] = 16'd0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic         ef;
        logic [W-1:0] e;
        logic [W-1:0] be;
        int bad;
        ef = (ccount >= taps(weight_dim) + 1);
        tests++;
        if (conv_finish !== ef) begin
            fails++;
            $display("FAIL model_finish: got %0b expected %0b at %0t", conv_finish, ef, $time);
        end
        if (out_valid()) begin
            bad = -1;
            be = 16'd0;
            for (int c = 0; c < C; c++) begin
                e = exp_out(c);
                if (systolic_out[c] !== e && bad < 0) begin
                    bad = c;
                    be = e;
                end
            end
            tests++;
            if (bad >= 0) begin
                fails++;
                $display("FAIL model_out col %0d: got %0h expected %0h at %0t",
                         bad, systolic_out[bad], be, $time);
            end
        end
    endtask

    // Inputs are set at the falling edge; apply one rising edge, update the
    // reference, then compare at the next falling edge.
    task automatic step();
        @(posedge clk);
        if (n < HMAX)
            for (int r = 0; r < R; r++) xh[n][r] = feature_input2[r];
        if (|weight_en) begin
            for (int c = 0; c < C; c++) begin
                if (weight_en[c]) begin
                    for (int r = R - 1; r > 0; r--) wm[r][c] = wm[r-1][c];
                    wm[0][c] = weight_input2[c];
                end
            end
            last_wchange = n;
        end
        ccount = conv_ctrl ? ((ccount < 63) ? ccount + 1 : 63) : 0;
        n++;
        @(negedge clk);
        check_model();
    endtask

    task automatic zero_inputs();
        conv_ctrl = 1'b0;
        weight_en = '0;
        for (int c = 0; c < C; c++) weight_input2[c] = 16'd0;
        for (int r = 0; r < R; r++) feature_input2[r] = 16'd0;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        zero_inputs();
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        model_reset();
    endtask

    // Load columns 0 and 1, then run until column 1's first result.
    task automatic run_vector(input int i, input bit full);
        int t;
        weight_dim = vecs[i].dim;
        t = taps(vecs[i].dim);
        for (int s = 0; s < t; s++) begin
            weight_input2[0] = vecs[i].w;
            weight_input2[1] = vecs[i].w * 16'd2;
            weight_en = 32'h0000_0003;
            step();
        end
        weight_en = '0;
        for (int k = 0; k <= (full ? t + 1 : t); k++) begin
            conv_ctrl = 1'b1;
            for (int r = 0; r < R; r++)
                feature_input2[r] = (k >= 1 + r && r < t) ? vecs[i].f : 16'd0;
            step();
            if (k == t - 1) chk($sformatf("v%0d_finish_early", i), 32'(conv_finish), 32'd0);
            if (k == t) begin
                chk($sformatf("v%0d_col0", i), 32'(systolic_out[0]), 32'(vecs[i].e0));
                chk($sformatf("v%0d_finish", i), 32'(conv_finish), 32'd1);
                chk($sformatf("v%0d_col2_idle", i), 32'(systolic_out[2]), 32'd0);
            end
            if (k == t + 1)
                chk($sformatf("v%0d_col1", i), 32'(systolic_out[1]), 32'(vecs[i].e1));
        end
    endtask

    initial begin
        logic [C-1:0] en;
        logic         any_nz;

        vecs[0] = '{w: 16'd1,     f: 16'd1,     dim: 5'd25, e0: 16'd25,    e1: 16'd50};
        vecs[1] = '{w: 16'h0100,  f: 16'h0100,  dim: 5'd1,  e0: 16'h0000,  e1: 16'h0000};
        vecs[2] = '{w: 16'hFFFF,  f: 16'd2,     dim: 5'd1,  e0: 16'hFFFE,  e1: 16'hFFFC};
        vecs[3] = '{w: 16'd3,     f: 16'd5,     dim: 5'd0,  e0: 16'd480,   e1: 16'd960};
        vecs[4] = '{w: 16'd7,     f: 16'd9,     dim: 5'd31, e0: 16'd1953,  e1: 16'd3906};

        weight_dim = 5'd25;
        do_reset();
        chk("reset_finish", 32'(conv_finish), 32'd0);
        chk("reset_out0", 32'(systolic_out[0]), 32'd0);

        for (int i = 0; i < 5; i++) begin
            do_reset();
            run_vector(i, 1'b1);
        end

        // Tap ordering: first-loaded weight (1) ends up in row 24.
        do_reset();
        weight_dim = 5'd25;
        for (int s = 0; s < 25; s++) begin
            weight_input2[0] = 16'(s + 1);
            weight_en = 32'h0000_0001;
            step();
        end
        weight_en = '0;
        for (int k = 0; k <= 25; k++) begin
            conv_ctrl = 1'b1;
            feature_input2[24] = (k == 25) ? 16'd1 : 16'd0;
            step();
        end
        chk("tap_order", 32'(systolic_out[0]), 32'd1);
        zero_inputs();

        // Asynchronous reset while results are valid, then a clean re-run.
        do_reset();
        run_vector(0, 1'b0);
        #2 nrst = 1'b0;
        #1;
        chk("midrst_finish", 32'(conv_finish), 32'd0);
        any_nz = 1'b0;
        for (int c = 0; c < C; c++) any_nz |= (systolic_out[c] != 16'd0);
        chk("midrst_out_zero", 32'(any_nz), 32'd0);
        do_reset();
        run_vector(0, 1'b1);

        // conv_ctrl drop and restart.
        conv_ctrl = 1'b0;
        step();
        chk("drop_finish", 32'(conv_finish), 32'd0);
        for (int j = 0; j <= 25; j++) begin
            conv_ctrl = 1'b1;
            step();
            chk($sformatf("restart_finish_%0d", j), 32'(conv_finish), 32'(j >= 25));
        end

        // Randomized weights, enables, features and conv_ctrl.
        for (int it = 0; it < 4; it++) begin
            do_reset();
            weight_dim = 5'($urandom);
            en = C'($urandom);
            for (int s = 0; s < 32; s++) begin
                for (int c = 0; c < C; c++) weight_input2[c] = 16'($urandom);
                weight_en = en;
                step();
            end
            weight_en = '0;
            for (int k = 0; k < 100; k++) begin
                conv_ctrl = ($urandom_range(0, 7) != 0);
                for (int r = 0; r < R; r++) feature_input2[r] = 16'($urandom);
                if ($urandom_range(0, 15) == 0) begin
                    for (int c = 0; c < C; c++) weight_input2[c] = 16'($urandom);
                    weight_en = en;
                end else begin
                    weight_en = '0;
                end
                step();
            end
            zero_inputs();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
